delay_line_prog: RTL and testbench
==================================

# delay_line_prog

Clocked, parametrised request-delay line for the FPGA control fabric. Each of `CH` independent request channels gets a runtime-programmable delay of 1..`MAX_DELAY` clock cycles, with a selectable two-phase (transition) or pulse mode. Asynchronous `inR` inputs are synchronised internally. Any number of events may be in flight at once. Delay changes apply only when the line is drained, so no event is lost, duplicated or re-timed mid-flight.

## Interface
- `CH`, 2: number of independent request channels.
- `MAX_DELAY`, 16: longest programmable delay in cycles, and the shift-register depth per channel.
- `DW`, 5: width of `cfgDelay`; must satisfy 2^DW > `MAX_DELAY`.
- `SYNC_STAGES`, 2: synchroniser flops per channel, ≥2.
- `DEFAULT_DELAY`, 4: delay in force after reset, 1..`MAX_DELAY`.
- `MODE`, 0: 0 = two-phase (every `inR` transition produces one `outR` transition); 1 = pulse (every `inR` rising edge produces a one-cycle `outR` high).

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-low reset.
- `inR` input CH: request inputs, asynchronous to `clk`.
- `outR` output CH: delayed requests, registered.
- `cfgDelay` input DW: requested delay value.
- `cfgLoad` input 1: one-cycle strobe that captures `cfgDelay`.
- `cfgBusy` output 1: high while a captured delay is pending application.
- `lineEmpty` output 1: high when no event is in flight on any channel.

## Operation
**Per-channel datapath**
- Synchroniser chain `sync[0..S-1]`, followed by a previous-value flop `prev`.
- Event detection: `evt = sync[S-1] ^ prev` in MODE 0, or `sync[S-1] & ~prev` in MODE 1.
- Shift register `sr[0..MAX_DELAY-1]` with `sr[0] <= evt` and `sr[k] <= sr[k-1]`.
- Output tap is `sr[curDelay-1]`.
  - MODE 0: `outR <= outR ^ tap`.
  - MODE 1: `outR <= tap`.

**Delay clamp**
- Captured value 0 becomes 1.
- Captured value greater than `MAX_DELAY` becomes `MAX_DELAY`.

**Configuration FSM** (two states)
- RUN
  - `cfgLoad` captures the clamped `cfgDelay` into `pendDelay` and moves to PEND.
  - `cfgBusy` is 0.
- PEND
  - `cfgBusy` is 1.
  - When `lineEmpty` is 1 and no channel has `evt` this cycle: `curDelay <= pendDelay`, return to RUN.
  - While waiting, events continue to propagate with the old `curDelay`.
  - `cfgLoad` in PEND overwrites `pendDelay`; last load wins; state stays PEND.
- `lineEmpty` = NOR over all `sr` bits of all channels.
  - `sr` bits beyond the current tap are also cleared by the time the line counts as empty: the whole register must be zero.

**Reset** (`rst` low at a clock edge)
- `sync`, `prev`, `sr`, `outR` all go to 0.
- `curDelay` and `pendDelay` go to `DEFAULT_DELAY`.
- FSM goes to RUN; `cfgBusy` = 0; `lineEmpty` = 1.
- Reset asserted mid-flight discards every in-flight event; no `outR` activity follows for them.
- `inR` high at reset release is seen as a transition (`prev` = 0). In MODE 0 `outR` therefore ends at 1, tracking `inR`.

## Timing
**Latency**
- Let edge 0 be the first rising edge sampling the new `inR` value. `outR` changes on edge `S + curDelay`.
- Example, S=2, D=4: `outR` changes 6 cycles after capture.

**Throughput**
- One event per channel per cycle is accepted.
- MODE 0: `inR` transitions closer than `S` cycles apart may be merged by the synchroniser. The guaranteed minimum spacing for lossless tracking is 1 stable sample, i.e. the input must be held ≥2 clock periods.
- MODE 1: pulses on `outR` replicate the spacing of detected rising edges exactly.

**Configuration path**
- `cfgLoad` on edge n gives `cfgBusy` = 1 after edge n.
- If the line is already empty with no `evt`, `curDelay` updates on edge n+1 and `cfgBusy` returns to 0 after edge n+1.
- An event detected on the same cycle the apply condition would be met blocks the apply. That event uses the old delay.

**Simultaneous events**
- `cfgLoad` during a reset cycle is ignored.
- Simultaneous events on different channels are fully independent.
- The new delay applies only to events detected after the edge that updates `curDelay`.

## Test plan
All tests use CH=2, MAX_DELAY=8, S=2, DEFAULT_DELAY=4.
- **Reset:** hold `rst`=0 for 3 cycles with `inR`=2'b00 → `outR`=0, `cfgBusy`=0, `lineEmpty`=1. Then raise `inR[0]` → `outR[0]` rises exactly 6 cycles after the capturing edge; `outR[1]` stays 0.
- **MODE 0 multiple in flight:** toggle `inR[0]` every 3 cycles, 4 times → `outR[0]` reproduces 4 transitions, each 6 cycles after its capture, with 3-cycle spacing preserved.
- **MODE 1:** drive a rising edge on `inR[1]`, hold high for 5 cycles, then fall → exactly one 1-cycle `outR[1]` pulse 6 cycles after capture; the falling edge produces nothing.
- **Deferred config:** start an event, then `cfgLoad` with `cfgDelay`=2 two cycles later → in-flight event still exits at 6 cycles; `cfgBusy` stays high until the line drains. The next event exits at 4 cycles (S+2).
- **Clamp:** `cfgLoad` with 0 on an idle line → delay 1, latency 3. `cfgLoad` with 31 → delay 8, latency 10.
- **Reset mid-flight:** reset 2 cycles after an event is captured → `outR` stays 0 with no late pulse; `curDelay` is back to 4.

Source files
------------

// File: rtl/delay_line_prog.sv
// Programmable per-channel request delay line with synchronised inputs,
// two-phase or pulse event mode, and delay changes deferred until the line drains.
module delay_line_prog #(
  parameter int unsigned CH            = 2,
  parameter int unsigned MAX_DELAY     = 16,
  parameter int unsigned DW            = 5,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned DEFAULT_DELAY = 4,
  parameter int unsigned MODE          = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] inR,
  output logic [CH-1:0] outR,
  input  logic [DW-1:0] cfgDelay,
  input  logic          cfgLoad,
  output logic          cfgBusy,
  output logic          lineEmpty
);

  localparam int unsigned S = SYNC_STAGES;
  localparam int unsigned D = MAX_DELAY;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  logic [CH-1:0][S-1:0] sync_q, sync_d;
  logic [CH-1:0]        prev_q, prev_d;
  logic [CH-1:0][D-1:0] sr_q, sr_d;
  logic [CH-1:0]        out_q, out_d;
  logic [DW-1:0]        cur_delay_q, cur_delay_d;
  logic [DW-1:0]        pend_delay_q, pend_delay_d;
  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 empty_q, empty_d;

  logic [CH-1:0]        evt_c;
  logic [CH-1:0]        tap_c;
  logic [DW-1:0]        cfg_clamp_c;

  // Per-channel synchroniser, edge detect, shift register and output tap
  always_comb begin
    sync_d = sync_q;
    prev_d = prev_q;
    sr_d   = sr_q;
    out_d  = out_q;
    evt_c  = '0;
    tap_c  = '0;
    for (int c = 0; c < int'(CH); c++) begin
      sync_d[c] = {sync_q[c][S-2:0], inR[c]};
      prev_d[c] = sync_q[c][S-1];
      if (MODE == 0) evt_c[c] = sync_q[c][S-1] ^ prev_q[c];
      else           evt_c[c] = sync_q[c][S-1] & ~prev_q[c];
      sr_d[c] = {sr_q[c][D-2:0], evt_c[c]};
      for (int k = 0; k < int'(D); k++) begin
        if (cur_delay_q == DW'(k + 1)) tap_c[c] = sr_q[c][k];
      end
      if (MODE == 0) out_d[c] = out_q[c] ^ tap_c[c];
      else           out_d[c] = tap_c[c];
    end
    // Registered view of the drained condition; tracks the whole register, not just the tap
    empty_d = ~|sr_d;
  end

  // Clamp requested delay into 1..MAX_DELAY
  always_comb begin
    cfg_clamp_c = cfgDelay;
    if (cfgDelay == '0)                 cfg_clamp_c = DW'(1);
    else if (cfgDelay > DW'(MAX_DELAY)) cfg_clamp_c = DW'(MAX_DELAY);
  end

  // Config FSM: apply only when drained and no new event is entering this cycle
  always_comb begin
    state_d      = state_q;
    cur_delay_d  = cur_delay_q;
    pend_delay_d = pend_delay_q;
    case (state_q)
      ST_RUN: begin
        if (cfgLoad) begin
          pend_delay_d = cfg_clamp_c;
          state_d      = ST_PEND;
        end
      end
      ST_PEND: begin
        if (cfgLoad) begin
          pend_delay_d = cfg_clamp_c;
        end else if (empty_q && !(|evt_c)) begin
          cur_delay_d = pend_delay_q;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    busy_d = (state_d == ST_PEND);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q       <= '0;
      prev_q       <= '0;
      sr_q         <= '0;
      out_q        <= '0;
      cur_delay_q  <= DW'(DEFAULT_DELAY);
      pend_delay_q <= DW'(DEFAULT_DELAY);
      state_q      <= ST_RUN;
      busy_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      sr_q         <= sr_d;
      out_q        <= out_d;
      cur_delay_q  <= cur_delay_d;
      pend_delay_q <= pend_delay_d;
      state_q      <= state_d;
      busy_q       <= busy_d;
      empty_q      <= empty_d;
    end
  end

  assign outR      = out_q;
  assign cfgBusy   = busy_q;
  assign lineEmpty = empty_q;

endmodule

// File: tb/tb_delay_line_prog.sv
// Directed bench for delay_line_prog: one two-phase instance and one pulse-mode
// instance, CH=2, MAX_DELAY=8, S=2, DEFAULT_DELAY=4. Drive and sample on negedge.
module tb_delay_line_prog;

  logic       clk;
  logic       rst;
  logic [1:0] in0, in1, out0, out1;
  logic [4:0] dly0, dly1;
  logic       ld0, ld1;
  logic       busy0, busy1, emp0, emp1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  delay_line_prog #(
    .CH(2), .MAX_DELAY(8), .DW(5), .SYNC_STAGES(2), .DEFAULT_DELAY(4), .MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst), .inR(in0), .outR(out0),
    .cfgDelay(dly0), .cfgLoad(ld0), .cfgBusy(busy0), .lineEmpty(emp0)
  );

  delay_line_prog #(
    .CH(2), .MAX_DELAY(8), .DW(5), .SYNC_STAGES(2), .DEFAULT_DELAY(4), .MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst), .inR(in1), .outR(out1),
    .cfgDelay(dly1), .cfgLoad(ld1), .cfgBusy(busy1), .lineEmpty(emp1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset;
    logic [1:0] exp_o;
    logic       exp_e;
    rst = 1'b0; in0 = 2'b00; in1 = 2'b00;
    ld0 = 1'b1; dly0 = 5'd2; ld1 = 1'b0; dly1 = 5'd0;
    repeat (3) @(negedge clk);
    total_cnt++; if (out0 !== 2'b00) $display("FAIL reset_out0 got=%b exp=00", out0); else pass_cnt++;
    total_cnt++; if (out1 !== 2'b00) $display("FAIL reset_out1 got=%b exp=00", out1); else pass_cnt++;
    total_cnt++; if (busy0 !== 1'b0) $display("FAIL reset_busy0 got=%b exp=0", busy0); else pass_cnt++;
    total_cnt++; if (emp0 !== 1'b1) $display("FAIL reset_empty0 got=%b exp=1", emp0); else pass_cnt++;
    total_cnt++; if (emp1 !== 1'b1) $display("FAIL reset_empty1 got=%b exp=1", emp1); else pass_cnt++;
    rst = 1'b1; ld0 = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy0 !== 1'b0) $display("FAIL reset_load_ignored busy=%b exp=0", busy0); else pass_cnt++;
    in0 = 2'b01;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      exp_o = (k >= 6) ? 2'b01 : 2'b00;
      exp_e = (k < 2 || k >= 10);
      total_cnt++;
      if (out0 !== exp_o) $display("FAIL reset_latency k=%0d got=%b exp=%b", k, out0, exp_o); else pass_cnt++;
      total_cnt++;
      if (emp0 !== exp_e) $display("FAIL reset_line_empty k=%0d got=%b exp=%b", k, emp0, exp_e); else pass_cnt++;
    end
  endtask

  task automatic test_mode0_multi;
    logic [1:0] exp_o;
    int n;
    for (int c = 0; c < 22; c++) begin
      if ((c % 3) == 0 && c < 12) in0[0] = ~in0[0];
      @(negedge clk);
      n = 0;
      for (int i = 0; i < 4; i++) if (3 * i + 6 <= c) n++;
      exp_o = {1'b0, ~n[0]};
      total_cnt++;
      if (out0 !== exp_o) $display("FAIL mode0_multi c=%0d got=%b exp=%b", c, out0, exp_o); else pass_cnt++;
    end
  endtask

  task automatic test_mode1;
    logic [1:0] exp_o;
    for (int c = 0; c <= 16; c++) begin
      if (c == 0) in1[1] = 1'b1;
      if (c == 5) in1[1] = 1'b0;
      @(negedge clk);
      exp_o = (c == 6) ? 2'b10 : 2'b00;
      total_cnt++;
      if (out1 !== exp_o) $display("FAIL mode1_pulse c=%0d got=%b exp=%b", c, out1, exp_o); else pass_cnt++;
    end
  endtask

  task automatic test_deferred_cfg;
    logic [1:0] exp_o;
    logic       exp_b;
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) in0[0] = 1'b0;
      if (c == 2) begin ld0 = 1'b1; dly0 = 5'd2; end
      if (c == 3) ld0 = 1'b0;
      @(negedge clk);
      exp_o = (c >= 6) ? 2'b00 : 2'b01;
      exp_b = (c >= 2 && c <= 10);
      total_cnt++;
      if (out0 !== exp_o) $display("FAIL deferred_old_delay c=%0d got=%b exp=%b", c, out0, exp_o); else pass_cnt++;
      total_cnt++;
      if (busy0 !== exp_b) $display("FAIL deferred_busy c=%0d got=%b exp=%b", c, busy0, exp_b); else pass_cnt++;
    end
    for (int c = 0; c <= 11; c++) begin
      if (c == 0) in0[0] = 1'b1;
      @(negedge clk);
      exp_o = (c >= 4) ? 2'b01 : 2'b00;
      total_cnt++;
      if (out0 !== exp_o) $display("FAIL deferred_new_delay c=%0d got=%b exp=%b", c, out0, exp_o); else pass_cnt++;
    end
  endtask

  task automatic test_clamp;
    logic [1:0] exp_o;
    for (int c = 0; c <= 1; c++) begin
      if (c == 0) begin ld0 = 1'b1; dly0 = 5'd0; end
      if (c == 1) ld0 = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (busy0 !== (c == 0)) $display("FAIL clamp0_busy c=%0d got=%b exp=%b", c, busy0, (c == 0)); else pass_cnt++;
    end
    for (int c = 0; c <= 11; c++) begin
      if (c == 0) in0[0] = 1'b0;
      @(negedge clk);
      exp_o = (c >= 3) ? 2'b00 : 2'b01;
      total_cnt++;
      if (out0 !== exp_o) $display("FAIL clamp0_latency c=%0d got=%b exp=%b", c, out0, exp_o); else pass_cnt++;
    end
    for (int c = 0; c <= 1; c++) begin
      if (c == 0) begin ld0 = 1'b1; dly0 = 5'd31; end
      if (c == 1) ld0 = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (busy0 !== (c == 0)) $display("FAIL clamp31_busy c=%0d got=%b exp=%b", c, busy0, (c == 0)); else pass_cnt++;
    end
    for (int c = 0; c <= 12; c++) begin
      if (c == 0) in0[0] = 1'b1;
      @(negedge clk);
      exp_o = (c >= 10) ? 2'b01 : 2'b00;
      total_cnt++;
      if (out0 !== exp_o) $display("FAIL clamp31_latency c=%0d got=%b exp=%b", c, out0, exp_o); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midflight;
    logic [1:0] exp_o;
    for (int c = 0; c <= 14; c++) begin
      if (c == 0) in0[0] = 1'b0;
      if (c == 2) rst = 1'b0;
      if (c == 3) rst = 1'b1;
      @(negedge clk);
      exp_o = (c < 2) ? 2'b01 : 2'b00;
      total_cnt++;
      if (out0 !== exp_o) $display("FAIL midreset_out c=%0d got=%b exp=%b", c, out0, exp_o); else pass_cnt++;
      if (c >= 2) begin
        total_cnt++;
        if (emp0 !== 1'b1) $display("FAIL midreset_empty c=%0d got=%b exp=1", c, emp0); else pass_cnt++;
      end
    end
    total_cnt++; if (busy0 !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", busy0); else pass_cnt++;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) in0[0] = 1'b1;
      @(negedge clk);
      exp_o = (c >= 6) ? 2'b01 : 2'b00;
      total_cnt++;
      if (out0 !== exp_o) $display("FAIL midreset_default_delay c=%0d got=%b exp=%b", c, out0, exp_o); else pass_cnt++;
    end
  endtask

  task automatic test_dual_channel;
    logic [1:0] exp_o0, exp_o1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 0) begin in0 = 2'b10; in1 = 2'b11; end
      @(negedge clk);
      exp_o0 = (c >= 6) ? 2'b10 : 2'b01;
      exp_o1 = (c == 6) ? 2'b11 : 2'b00;
      total_cnt++;
      if (out0 !== exp_o0) $display("FAIL dual_mode0 c=%0d got=%b exp=%b", c, out0, exp_o0); else pass_cnt++;
      total_cnt++;
      if (out1 !== exp_o1) $display("FAIL dual_mode1 c=%0d got=%b exp=%b", c, out1, exp_o1); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_mode0_multi();
    test_mode1();
    test_deferred_cfg();
    test_clamp();
    test_reset_midflight();
    test_dual_channel();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
